// File: rtl/sram_access_ctrl.sv
`default_nettype none
// ============================================================================
// sram_access_ctrl : single-word read/write sequencer for an 8x32 SRAM macro
//                    with 32/16/8-bit word modes. Optional macro: SRAM_CTRL_ERR_EN
// Revision 1.0
// ============================================================================
module sram_access_ctrl #(
  parameter int ROWS   = 8,
  parameter int ROW_W  = 32,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               cfg_conf,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [ROW_W-1:0]         req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ROW_W-1:0]         rsp_rdata,
  output logic                     rsp_err,
  output logic                     sram_en,
  output logic                     sram_we,
  output logic [$clog2(ROWS)-1:0]  sram_row,
  output logic [1:0]               sram_col,
  output logic [1:0]               sram_conf,
  output logic [ROW_W-1:0]         sram_wdata,
  input  logic [ROW_W-1:0]         sram_rdata
);

  localparam int ROW_AW = $clog2(ROWS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ROW_W-1:0]    rdata_q, rdata_d;
  logic [ROW_AW-1:0]   row_q, row_d;
  logic [1:0]          col_q, col_d;
  logic [1:0]          conf_q, conf_d;
  logic [ROW_W-1:0]    wdata_q, wdata_d;

  logic [1:0]          dec_conf;
  logic [ROW_AW-1:0]   dec_row;
  logic [1:0]          dec_col;
  logic [ROW_W-1:0]    dec_wdata;
  logic                req_err;
  logic [ROW_W-1:0]    rd_lane;

  // Request decode works straight off the port so the macro-side fields can
  // be captured at accept and then simply held until the next access.
  always_comb begin
    dec_conf = (cfg_conf == 2'b11) ? 2'b10 : cfg_conf;
    dec_row  = ROW_AW'(req_addr >> dec_conf);
    case (dec_conf)
      2'b00:   begin dec_col = 2'b00;                dec_wdata = req_wdata; end
      2'b01:   begin dec_col = {1'b0, req_addr[0]};  dec_wdata = {2{req_wdata[ROW_W/2-1:0]}}; end
      default: begin dec_col = req_addr[1:0];        dec_wdata = {4{req_wdata[ROW_W/4-1:0]}}; end
    endcase
`ifdef SRAM_CTRL_ERR_EN
    req_err = (cfg_conf == 2'b11) || ((req_addr >> (ROW_AW + int'(cfg_conf))) != '0);
`else
    req_err = 1'b0;
`endif
  end

  always_comb begin
    rd_lane = (sram_rdata >> (int'(col_q) * (ROW_W >> conf_q)))
            & ({ROW_W{1'b1}} >> (ROW_W - (ROW_W >> conf_q)));
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    row_d   = row_q;
    col_d   = col_q;
    conf_d  = conf_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          err_d   = req_err;
          rdata_d = '0;
          if (req_err) begin
            state_d = S_RESP;
          end else begin
            row_d   = dec_row;
            col_d   = dec_col;
            conf_d  = dec_conf;
            wdata_d = dec_wdata;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = 2'(RD_LAT);
        state_d = we_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd1) begin
          rdata_d = rd_lane;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
      rdata_q <= '0;
      row_q   <= '0;
      col_q   <= 2'b00;
      conf_q  <= 2'b00;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      row_q   <= row_d;
      col_q   <= col_d;
      conf_q  <= conf_d;
      wdata_q <= wdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign sram_en    = (state_q == S_ISSUE);
  assign sram_we    = (state_q == S_ISSUE) && we_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign sram_row   = row_q;
  assign sram_col   = col_q;
  assign sram_conf  = conf_q;
  assign sram_wdata = wdata_q;

endmodule
`default_nettype wire
